// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - digit keypad synchronizer, debounce FSM and multi-key rejection
module keypad_debounce #(
  parameter int DEB_CNT = 20,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_raw,
  output logic [9:0] key_clean,
  output logic       key_valid,
  output logic [3:0] key_digit,
  output logic       key_err
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE,
    LOCKOUT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [9:0]       sync_1;
  logic [9:0]       key_s;
  state_t           state;
  state_t           state_n;
  logic [9:0]       cand;
  logic [9:0]       cand_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [9:0]       clean_n;
  logic             valid_n;
  logic [3:0]       digit_n;
  logic             err_n;
  logic [3:0]       cand_digit;
  logic             s_onehot;
  logic             s_zero;

  // Two-flop synchronizer; key_raw is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      key_s  <= '0;
    end else begin
      sync_1 <= key_raw;
      key_s  <= sync_1;
    end
  end

  // Binary index of the candidate key (cand is one-hot whenever it is used).
  always_comb begin
    cand_digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (cand[i]) cand_digit = 4'(i);
    end
  end

  assign s_onehot = $onehot(key_s);
  assign s_zero   = (key_s == '0);

  // State register plus all registered outputs, so nothing glitches downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_clean <= '0;
      key_valid <= 1'b0;
      key_digit <= '0;
      key_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_clean <= clean_n;
      key_valid <= valid_n;
      key_digit <= digit_n;
      key_err   <= err_n;
    end
  end

  // Next-state logic; the counter saturates at CNT_MAX because every state leaves on reaching it.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    clean_n = key_clean;
    valid_n = 1'b0;
    digit_n = key_digit;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (s_onehot) begin
          cand_n  = key_s;
          cnt_n   = '0;
          state_n = DEB_PRESS;
        end else if (!s_zero) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = LOCKOUT;
        end
      end
      DEB_PRESS: begin
        if (key_s == cand) begin
          if (cnt == CNT_MAX) begin
            state_n = PRESSED;
            valid_n = 1'b1;
            clean_n = cand;
            digit_n = cand_digit;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      PRESSED: begin
        if (key_s != cand) begin
          cnt_n   = '0;
          state_n = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (key_s == cand) begin
          state_n = PRESSED;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE;
          clean_n = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      LOCKOUT: begin
        if (!s_zero) begin
          cnt_n = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
